// File: rtl/lsu_seq.sv
// lsu_seq: sequential load/store unit with a valid/ready request port, a
// Wishbone-style cyc/stb/ack/err bus master and a registered response.
// Parameters: XLEN (32 or 64), TIMEOUT (stb cycles per beat, 0 = no timeout).
// Optional macro LSU_MISALIGN_SPLIT_EN: lane-crossing accesses are split into
// two bus beats instead of faulting. Without it, misaligned accesses fault
// and BEAT2 is never entered.

// Per-lane store-data byte select: either replicates the access across the
// bus (aligned-only build) or rotates it left by the byte offset (split build).
module lsu_seq_lane #(
  parameter int NB    = 4,
  parameter int LANE  = 0,
  parameter bit SPLIT = 1'b0
) (
  input  logic [NB-1:0][7:0]      src,
  input  logic [$clog2(NB)-1:0]   off,
  input  logic [3:0]              size,
  output logic [7:0]              q
);
  localparam int OW = $clog2(NB);
  localparam logic [OW-1:0] LI = OW'(LANE);

  logic [3:0]    sm1;
  logic [OW-1:0] idx;

  // pick the source byte that lands on this lane
  always_comb begin
    sm1 = size - 4'd1;
    idx = SPLIT ? (LI - off) : (LI & sm1[OW-1:0]);
    q   = src[idx];
  end
endmodule

module lsu_seq #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [XLEN-1:0]   req_dat_i,
  input  logic [1:0]        req_type_i,
  input  logic              req_sign_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  output logic              lsu_cyc_o,
  output logic              lsu_stb_o,
  output logic              lsu_we_o,
  output logic [31:0]       lsu_addr_o,
  output logic [XLEN/8-1:0] lsu_sel_o,
  output logic [XLEN-1:0]   lsu_dat_o,
  input  logic [XLEN-1:0]   lsu_dat_i,
  input  logic              lsu_ack_i,
  input  logic              lsu_err_i
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

  // request fields still needed after acceptance
  typedef struct packed {
    logic          we;
    logic [OW-1:0] off;
    logic [1:0]    typ;
    logic          sign;
  } req_t;

  function automatic logic [3:0] size_of(input logic [1:0] t);
    case (t)
      2'b01:   size_of = 4'd1;
      2'b10:   size_of = 4'd2;
      2'b11:   size_of = 4'd4;
      default: size_of = 4'd8;
    endcase
  endfunction

  state_t            state, nxt;
  req_t              req, n_req;
  logic              cyc, stb, we, n_cyc, n_stb, n_we;
  logic [31:0]       addr, n_addr;
  logic [NB-1:0]     sel, n_sel, sel2, n_sel2;
  logic [XLEN-1:0]   wdat, n_wdat, rd1, n_rd1;
  logic              split, n_split;
  logic [CW-1:0]     cnt, n_cnt;
  logic              rvld, rerr, n_rvld, n_rerr;
  logic [XLEN-1:0]   rdat, n_rdat;

  // request decode, evaluated on the incoming fields
  logic [OW-1:0]     off_in;
  logic [3:0]        size_in, sm1_in;
  logic [15:0]       mask_in;
  logic [2*NB-1:0]   sel_w;
  logic              illegal_in, misal_in, cross_in, fault_in;
  logic [NB-1:0][7:0] wsrc, wlane;

  // load merge/extension on the stored request
  logic [OW-1:0]     r_off;
  logic [3:0]        r_size;
  logic [XLEN-1:0]   b1, b2, merged, ext;
  logic              fill;
  int unsigned       sh1, sh2;
  logic              tmo_hit;

  assign off_in = req_addr_i[OW-1:0];
  assign wsrc   = req_dat_i;

  // size, lane mask, fault and lane-crossing classification of the request
  always_comb begin
    size_in    = size_of(req_type_i);
    sm1_in     = size_in - 4'd1;
    mask_in    = (16'd1 << size_in) - 16'd1;
    sel_w      = mask_in[2*NB-1:0] << off_in;
    illegal_in = (XLEN == 32) && (req_type_i == 2'b00);
    misal_in   = (off_in & sm1_in[OW-1:0]) != '0;
    cross_in   = SPLIT_EN &&
                 (({{(5-OW){1'b0}}, off_in} + {1'b0, size_in}) > 5'(NB));
    fault_in   = illegal_in || (!SPLIT_EN && misal_in);
  end

  for (genvar l = 0; l < NB; l++) begin : g_lane
    lsu_seq_lane #(.NB(NB), .LANE(l), .SPLIT(SPLIT_EN)) u_lane (
      .src  (wsrc),
      .off  (off_in),
      .size (size_in),
      .q    (wlane[l])
    );
  end

  assign r_off  = req.off;
  assign r_size = size_of(req.typ);

  // merge {beat2 low bytes, beat1 high bytes}, then size/sign extend
  always_comb begin
    b1     = split ? rd1 : lsu_dat_i;
    b2     = split ? lsu_dat_i : '0;
    sh1    = 8 * r_off;
    sh2    = 8 * (NB - r_off);
    merged = (b1 >> sh1) | (b2 << sh2);
    case (r_size)
      4'd1:    fill = req.sign & merged[7];
      4'd2:    fill = req.sign & merged[15];
      4'd4:    fill = req.sign & merged[31];
      default: fill = 1'b0;
    endcase
    ext = '0;
    for (int i = 0; i < NB; i++)
      ext[8*i +: 8] = (i < int'(r_size)) ? merged[8*i +: 8] : {8{fill}};
  end

  assign tmo_hit = (TIMEOUT != 0) && (cnt == TMO_LAST);

  // next-state and next registered outputs
  always_comb begin
    nxt     = state;
    n_req   = req;
    n_cyc   = cyc;
    n_stb   = stb;
    n_we    = we;
    n_addr  = addr;
    n_sel   = sel;
    n_sel2  = sel2;
    n_wdat  = wdat;
    n_rd1   = rd1;
    n_split = split;
    n_cnt   = cnt;
    n_rvld  = 1'b0;
    n_rerr  = rerr;
    n_rdat  = rdat;
    case (state)
      IDLE: if (req_valid_i) begin
        n_req = '{we: req_we_i, off: off_in, typ: req_type_i, sign: req_sign_i};
        if (fault_in) begin
          nxt    = RESP;
          n_rvld = 1'b1;
          n_rerr = 1'b1;
          n_rdat = '0;
        end else begin
          nxt     = BEAT1;
          n_cyc   = 1'b1;
          n_stb   = 1'b1;
          n_we    = req_we_i;
          n_addr  = {req_addr_i[31:OW], {OW{1'b0}}};
          n_sel   = sel_w[NB-1:0];
          n_sel2  = sel_w[2*NB-1:NB];
          n_wdat  = wlane;
          n_split = cross_in;
          n_cnt   = '0;
        end
      end
      BEAT1, BEAT2: begin
        if (!stb) begin
          // one-cycle stb gap between split beats; second beat starts here
          n_stb = 1'b1;
          n_cnt = '0;
        end else if (lsu_err_i || (!lsu_ack_i && tmo_hit)) begin
          nxt    = RESP;
          n_cyc  = 1'b0;
          n_stb  = 1'b0;
          n_we   = 1'b0;
          n_rvld = 1'b1;
          n_rerr = 1'b1;
          n_rdat = '0;
        end else if (lsu_ack_i) begin
          if (state == BEAT1 && split) begin
            nxt    = BEAT2;
            n_stb  = 1'b0;
            n_addr = addr + 32'(NB);
            n_sel  = sel2;
            n_rd1  = lsu_dat_i;
          end else begin
            nxt    = RESP;
            n_cyc  = 1'b0;
            n_stb  = 1'b0;
            n_we   = 1'b0;
            n_rvld = 1'b1;
            n_rerr = 1'b0;
            n_rdat = req.we ? '0 : ext;
          end
        end else begin
          n_cnt = cnt + CW'(1);
        end
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state and registered outputs, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      req   <= '0;
      cyc   <= 1'b0;
      stb   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      sel   <= '0;
      sel2  <= '0;
      wdat  <= '0;
      rd1   <= '0;
      split <= 1'b0;
      cnt   <= '0;
      rvld  <= 1'b0;
      rerr  <= 1'b0;
      rdat  <= '0;
    end else begin
      state <= nxt;
      req   <= n_req;
      cyc   <= n_cyc;
      stb   <= n_stb;
      we    <= n_we;
      addr  <= n_addr;
      sel   <= n_sel;
      sel2  <= n_sel2;
      wdat  <= n_wdat;
      rd1   <= n_rd1;
      split <= n_split;
      cnt   <= n_cnt;
      rvld  <= n_rvld;
      rerr  <= n_rerr;
      rdat  <= n_rdat;
    end
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = rvld;
  assign rsp_err_o   = rerr;
  assign rsp_dat_o   = rdat;
  assign lsu_cyc_o   = cyc;
  assign lsu_stb_o   = stb;
  assign lsu_we_o    = we;
  assign lsu_addr_o  = addr;
  assign lsu_sel_o   = sel;
  assign lsu_dat_o   = wdat;
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed bench for lsu_seq. A 32-bit instance (TIMEOUT=4) and a
// 64-bit instance share the stimulus; use64 selects which one is driven and
// observed. Expected responses go into a scoreboard queue that a separate
// monitor drains on every rsp_valid_o pulse.
module tb_lsu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use64 = 1'b0;
  logic        req_valid = 1'b0, we = 1'b0, sign = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] dat = '0, bus_rd = '0;
  logic [1:0]  typ = 2'b11;
  logic        ack = 1'b0, err = 1'b0;

  logic        rdy32, rv32, re32, cyc32, stb32, we32;
  logic [31:0] rd32, ad32, wd32;
  logic [3:0]  sel32;
  logic        rdy64, rv64, re64, cyc64, stb64, we64;
  logic [63:0] rd64, wd64;
  logic [31:0] ad64;
  logic [7:0]  sel64;

  always #5 clk = ~clk;

  lsu_seq #(.XLEN(32), .TIMEOUT(4)) dut32 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & ~use64), .req_ready_o(rdy32),
    .req_we_i(we), .req_addr_i(addr), .req_dat_i(dat[31:0]), .req_type_i(typ),
    .req_sign_i(sign), .rsp_valid_o(rv32), .rsp_dat_o(rd32), .rsp_err_o(re32),
    .lsu_cyc_o(cyc32), .lsu_stb_o(stb32), .lsu_we_o(we32), .lsu_addr_o(ad32),
    .lsu_sel_o(sel32), .lsu_dat_o(wd32), .lsu_dat_i(bus_rd[31:0]),
    .lsu_ack_i(ack & ~use64), .lsu_err_i(err & ~use64));

  lsu_seq #(.XLEN(64), .TIMEOUT(16)) dut64 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & use64), .req_ready_o(rdy64),
    .req_we_i(we), .req_addr_i(addr), .req_dat_i(dat), .req_type_i(typ),
    .req_sign_i(sign), .rsp_valid_o(rv64), .rsp_dat_o(rd64), .rsp_err_o(re64),
    .lsu_cyc_o(cyc64), .lsu_stb_o(stb64), .lsu_we_o(we64), .lsu_addr_o(ad64),
    .lsu_sel_o(sel64), .lsu_dat_o(wd64), .lsu_dat_i(bus_rd),
    .lsu_ack_i(ack & use64), .lsu_err_i(err & use64));

  wire        m_ready = use64 ? rdy64 : rdy32;
  wire        m_rvld  = use64 ? rv64  : rv32;
  wire        m_rerr  = use64 ? re64  : re32;
  wire [63:0] m_rdat  = use64 ? rd64  : {32'b0, rd32};
  wire        m_cyc   = use64 ? cyc64 : cyc32;
  wire        m_stb   = use64 ? stb64 : stb32;
  wire        m_we    = use64 ? we64  : we32;
  wire [31:0] m_addr  = use64 ? ad64  : ad32;
  wire [7:0]  m_sel   = use64 ? sel64 : {4'b0, sel32};
  wire [63:0] m_wdat  = use64 ? wd64  : {32'b0, wd32};

  typedef struct packed { logic [63:0] dat; logic err; } rsp_t;
  rsp_t sbq[$];
  rsp_t exp_r;
  int   checks = 0, failures = 0;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic [63:0] SB_WDAT = 64'hAB000000;
`else
  localparam logic [63:0] SB_WDAT = 64'hABABABAB;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [63:0] d, input logic e);
    sbq.push_back('{dat: d, err: e});
  endtask

  // response monitor: every pulse must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && m_rvld) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%h expected=none", m_rdat);
      end else begin
        exp_r = sbq.pop_front();
        chk("rsp_dat", m_rdat, exp_r.dat);
        chk("rsp_err", {63'b0, m_rerr}, {63'b0, exp_r.err});
      end
    end
  end

  // present a request while idle; returns at the negedge of the cycle after acceptance
  task automatic issue(input logic w, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] t, input logic s);
    @(negedge clk);
    we = w; addr = a; dat = d; typ = t; sign = s; req_valid = 1'b1;
    chk("ready_idle", {63'b0, m_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // slave side of one beat; mode 0 ack, 1 err, 2 ack+err, 3 never respond
  task automatic beat(input string nm, input logic [31:0] ea, input logic [7:0] es,
                      input logic [63:0] ed, input logic ewe, input int waits,
                      input logic [63:0] rd, input int mode, input logic last);
    int n = 0;
    while (!m_stb && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_stb"},  {63'b0, m_stb}, 64'd1);
    chk({nm, "_cyc"},  {63'b0, m_cyc}, 64'd1);
    chk({nm, "_addr"}, {32'b0, m_addr}, {32'b0, ea});
    chk({nm, "_sel"},  {56'b0, m_sel}, {56'b0, es});
    chk({nm, "_wdat"}, m_wdat, ed);
    chk({nm, "_we"},   {63'b0, m_we}, {63'b0, ewe});
    if (mode == 3) begin
      n = 0;
      while (m_stb && n < 50) begin @(negedge clk); n++; end
      chk({nm, "_tmo_len"}, 64'(n), 64'(waits));
    end else begin
      repeat (waits) @(negedge clk);
      chk({nm, "_stb_hold"}, {63'b0, m_stb}, 64'd1);
      ack = (mode != 1); err = (mode != 0); bus_rd = rd;
      @(negedge clk);
      ack = 1'b0; err = 1'b0;
    end
    if (last) begin
      chk({nm, "_cyc_drop"}, {62'b0, m_cyc, m_stb}, 64'd0);
      chk({nm, "_rsp_time"}, {63'b0, m_rvld}, 64'd1);
      chk({nm, "_busy"}, {63'b0, m_ready}, 64'd0);
    end else begin
      chk({nm, "_gap"}, {62'b0, m_cyc, m_stb}, 64'd2);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'b0, rdy32}, 64'd1);
    chk("rst_ctl", {59'b0, cyc32, stb32, we32, rv32, re32}, 64'd0);
    chk("rst_bus", {ad32, 4'b0, sel32, 24'b0}, 64'd0);
    chk("rst_dat", {rd32, wd32}, 64'd0);
    chk("rst64", {rdy64, cyc64, stb64, rv64, sel64}, 64'h800);
    rst = 1'b0;

    // store byte, two wait states
    expect_rsp(64'h0, 1'b0);
    issue(1'b1, 32'h1003, 64'hAB, 2'b01, 1'b0);
    chk("stb_latency", {63'b0, m_stb}, 64'd1);
    beat("sb", 32'h1000, 8'h08, SB_WDAT, 1'b1, 2, 64'h0, 0, 1'b1);

    // load half signed / unsigned
    expect_rsp(64'hFFFF8001, 1'b0);
    issue(1'b0, 32'h2002, 64'h0, 2'b10, 1'b1);
    beat("lhs", 32'h2000, 8'h0C, 64'h0, 1'b0, 0, 64'h80011234, 0, 1'b1);
    expect_rsp(64'h00008001, 1'b0);
    issue(1'b0, 32'h2002, 64'h0, 2'b10, 1'b0);
    beat("lhu", 32'h2000, 8'h0C, 64'h0, 1'b0, 0, 64'h80011234, 0, 1'b1);

    // load byte signed / unsigned from lane 1
    expect_rsp(64'hFFFFFFC3, 1'b0);
    issue(1'b0, 32'h6001, 64'h0, 2'b01, 1'b1);
    beat("lbs", 32'h6000, 8'h02, 64'h0, 1'b0, 1, 64'h0000C300, 0, 1'b1);
    expect_rsp(64'h000000C3, 1'b0);
    issue(1'b0, 32'h6001, 64'h0, 2'b01, 1'b0);
    beat("lbu", 32'h6000, 8'h02, 64'h0, 1'b0, 0, 64'h0000C300, 0, 1'b1);

    // store word
    expect_rsp(64'h0, 1'b0);
    issue(1'b1, 32'h5000, 64'hDEADBEEF, 2'b11, 1'b0);
    beat("sw", 32'h5000, 8'h0F, 64'hDEADBEEF, 1'b1, 0, 64'h0, 0, 1'b1);

`ifndef LSU_MISALIGN_SPLIT_EN
    // misaligned word faults without a bus cycle
    expect_rsp(64'h0, 1'b1);
    issue(1'b0, 32'h3001, 64'h0, 2'b11, 1'b0);
    chk("mis_rsp_time", {63'b0, m_rvld}, 64'd1);
    chk("mis_no_cyc", {63'b0, m_cyc}, 64'd0);
    @(negedge clk);
    chk("mis_one_pulse", {62'b0, m_cyc, m_rvld}, 64'd0);
`endif

    // double on a 32-bit build is an illegal size
    expect_rsp(64'h0, 1'b1);
    issue(1'b0, 32'h3000, 64'h0, 2'b00, 1'b0);
    chk("ill_rsp_time", {63'b0, m_rvld}, 64'd1);
    chk("ill_no_cyc", {63'b0, m_cyc}, 64'd0);

    // timeout after 4 stb cycles, then ack+err together, then plain err
    expect_rsp(64'h0, 1'b1);
    issue(1'b0, 32'h4000, 64'h0, 2'b11, 1'b0);
    beat("tmo", 32'h4000, 8'h0F, 64'h0, 1'b0, 4, 64'h0, 3, 1'b1);
    expect_rsp(64'h0, 1'b1);
    issue(1'b0, 32'h4004, 64'h0, 2'b11, 1'b0);
    beat("ackerr", 32'h4004, 8'h0F, 64'h0, 1'b0, 1, 64'h12345678, 2, 1'b1);
    expect_rsp(64'h0, 1'b1);
    issue(1'b0, 32'h4008, 64'h0, 2'b11, 1'b0);
    beat("err", 32'h4008, 8'h0F, 64'h0, 1'b0, 0, 64'h12345678, 1, 1'b1);

`ifdef LSU_MISALIGN_SPLIT_EN
    // lane-crossing word splits into two beats
    expect_rsp(64'h5555AAAA, 1'b0);
    issue(1'b0, 32'h3002, 64'h0, 2'b11, 1'b0);
    beat("sp1", 32'h3000, 8'h0C, 64'h0, 1'b0, 0, 64'hAAAA0000, 0, 1'b0);
    beat("sp2", 32'h3004, 8'h03, 64'h0, 1'b0, 0, 64'h00005555, 0, 1'b1);
    expect_rsp(64'h0, 1'b1);
    issue(1'b0, 32'h3002, 64'h0, 2'b11, 1'b0);
    beat("sp_err", 32'h3000, 8'h0C, 64'h0, 1'b0, 0, 64'h0, 1, 1'b1);
    @(negedge clk);
    chk("sp_err_no_beat2", {63'b0, m_cyc}, 64'd0);
`endif

    // reset while waiting for ack discards the request
    issue(1'b0, 32'h7000, 64'h0, 2'b11, 1'b0);
    chk("rstmid_stb", {63'b0, m_stb}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_bus", {62'b0, m_cyc, m_stb}, 64'd0);
    chk("rstmid_ready", {63'b0, m_ready}, 64'd1);
    chk("rstmid_no_rsp", {63'b0, m_rvld}, 64'd0);
    repeat (3) @(negedge clk);

    // 64-bit instance
    use64 = 1'b1;
    expect_rsp(64'h1122334455667788, 1'b0);
    issue(1'b0, 32'h8, 64'h0, 2'b00, 1'b0);
    beat("ld64", 32'h8, 8'hFF, 64'h0, 1'b0, 1, 64'h1122334455667788, 0, 1'b1);
    expect_rsp(64'hFFFFFFFFFFFFFF80, 1'b0);
    issue(1'b0, 32'hF, 64'h0, 2'b01, 1'b1);
    beat("lb64", 32'h8, 8'h80, 64'h0, 1'b0, 0, 64'h8000000000000000, 0, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
Sequential load/store unit that sits between the pipeline MEM stage and the data bus. It replaces the single-cycle combinational LSU with a valid/ready request port, a Wishbone-style cyc/stb/ack/err bus master and a registered response. It is parametrised in data width (32 or 64 bits) and adds a bus timeout. Misaligned-access splitting is an optional compile-time feature.

Parameters:
XLEN, 32, data width; legal values 32 or 64. Lane count NB = XLEN/8.
TIMEOUT, 16, maximum number of stb cycles per bus beat without ack or err; 0 disables the timeout.

Ports:
clk_i  in  1  clock; all logic samples on the rising edge
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  LSU can accept a request
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  32  byte address
req_dat_i  in  XLEN  store data, right-justified
req_type_i  in  2  size code: 01 byte, 10 half, 11 word, 00 double (double is legal only when XLEN=64)
req_sign_i  in  1  load result is sign-extended when 1, zero-extended when 0
rsp_valid_o  out  1  one-cycle response pulse
rsp_dat_o  out  XLEN  load result, extended to XLEN; 0 for stores
rsp_err_o  out  1  access fault; qualified by rsp_valid_o
lsu_cyc_o  out  1  bus cycle active
lsu_stb_o  out  1  bus strobe
lsu_we_o  out  1  bus write
lsu_addr_o  out  32  address aligned to NB bytes
lsu_sel_o  out  NB  byte-lane select
lsu_dat_o  out  XLEN  bus write data
lsu_dat_i  in  XLEN  bus read data
lsu_ack_i  in  1  bus acknowledge
lsu_err_i  in  1  bus error

Behaviour:
- Reset values: req_ready_o=1. rsp_valid_o, rsp_err_o, lsu_cyc_o, lsu_stb_o and lsu_we_o are 0. rsp_dat_o, lsu_addr_o, lsu_sel_o and lsu_dat_o are 0.
- FSM states: IDLE, BEAT1, BEAT2, RESP.
  - IDLE: req_ready_o=1. A request is accepted on any cycle with req_valid_i=1; all request fields are registered.
  - From IDLE, a misaligned or illegal-size request goes to RESP with error set and issues no bus cycle. Any other request goes to BEAT1.
  - req_ready_o=0 in every state other than IDLE.
- Misaligned: offset = addr mod NB. A request is misaligned when the offset is not a multiple of the access size. An illegal size is type 00 with XLEN=32.
- BEAT1:
  - cyc, stb and we are registered high on entry and held stable, together with addr/sel/dat, until ack, err or timeout.
  - lsu_addr_o = addr with its low log2(NB) bits cleared.
  - lsu_sel_o = size mask (1, 3, 0xF or 0xFF) shifted left by offset.
  - lsu_dat_o = store data replicated across all lanes.
- Beat termination:
  - ack: capture lsu_dat_i, drop cyc/stb on the next edge, go to RESP.
  - err, or ack and err in the same cycle: err wins; go to RESP with error set.
- Timeout: a counter clears on beat start and increments each cycle stb is high without a termination. At count TIMEOUT it drops cyc/stb and goes to RESP with error set.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then the FSM returns to IDLE.
  - For loads, the lane at offset is extracted and sign-extended if req_sign_i=1, otherwise zero-extended.
  - There is no response backpressure; the pipeline must accept the response.
- Latency:
  - Request accepted at edge T; stb is high in cycle T+1.
  - Ack sampled at edge A gives rsp_valid_o high in cycle A+1.
  - A fault detected in IDLE gives rsp_valid_o in cycle T+1.
  - Minimum load-to-use is 3 cycles with a zero-wait-state slave.
- Reset mid-operation: on the edge where rst_i=1, the FSM returns to IDLE and cyc/stb drop. No response is produced and the in-flight request is discarded.
- req_valid_i while busy is ignored; the requester holds it until ready.

Optional Feature:
Macro LSU_MISALIGN_SPLIT_EN.
- Without it: misaligned accesses fault as described above; BEAT2 is unreachable and may be removed by synthesis.
- With it: an access crosses a lane boundary when offset + size > NB. Such accesses are not faulted and are split into two beats.
  - BEAT1 uses the aligned address and the upper lanes, sel = mask << offset truncated to NB.
  - BEAT2 uses address + NB and sel = mask >> (NB - offset).
  - Store data is rotated left by offset bytes on both beats.
  - Read data is merged as {beat2 low bytes, beat1 high bytes} before extension.
  - An error or timeout on BEAT1 skips BEAT2. The timeout counter restarts for BEAT2.
  - cyc stays high between the two beats; stb drops for one cycle between them.
  - Illegal-size requests still fault.

Test Plan:
1. XLEN=32. Store byte, addr 0x1003, data 0xAB -> lsu_addr_o=0x1000, sel=1000, lsu_dat_o=0xABABABAB, we=1. Ack after 2 wait cycles -> rsp_valid_o=1 with err=0 one cycle after ack.
2. Load half, signed, addr 0x2002, slave returns 0x80011234 -> sel=1100, rsp_dat_o=0xFFFF8001. Same access unsigned -> 0x00008001.
3. Load word at 0x3001, macro off -> lsu_cyc_o never rises; rsp_valid_o=1 with rsp_err_o=1 in cycle T+1. XLEN=32 with type 00 gives the same fault.
4. TIMEOUT=4, load word 0x4000, no ack -> stb high for 4 cycles, then cyc/stb=0 and rsp_err_o=1. Ack and err asserted together on another access -> rsp_err_o=1.
5. Macro on, load word at 0x3002 -> beat 1: addr 0x3000, sel=1100, data 0xAAAA0000; beat 2: addr 0x3004, sel=0011, data 0x00005555. Result rsp_dat_o=0x5555AAAA. Err on beat 1 -> no beat 2, rsp_err_o=1.
6. rst_i pulsed while stb is high awaiting ack -> next cycle cyc=stb=0 and req_ready_o=1, with no rsp_valid_o. XLEN=64 load double at 0x8 -> sel=0xFF, full 64-bit data returned.
